// File: rtl/edge_pkg.sv
// Shared widths, Sobel weights and gradient type for the edge-detection engine.
package edge_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned MAG_W_DEF = 8;

  // 1-2-1 smoothing weights; the centre row/column carries weight zero.
  localparam int KW_SIDE = 1;
  localparam int KW_MID  = 2;

  typedef logic signed [PIX_W_DEF+2:0] grad_t;

endpackage

// File: rtl/sobel_kernel3x3.sv
// Combinational Sobel Gx/Gy for one 3x3 neighbourhood a b c / d e f / g h i.
module sobel_kernel3x3
  import edge_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0]        a,
  input  logic [PIX_W-1:0]        b,
  input  logic [PIX_W-1:0]        c,
  input  logic [PIX_W-1:0]        d,
  input  logic [PIX_W-1:0]        f,
  input  logic [PIX_W-1:0]        g,
  input  logic [PIX_W-1:0]        h,
  input  logic [PIX_W-1:0]        i,
  output logic signed [PIX_W+2:0] gx,
  output logic signed [PIX_W+2:0] gy
);

  localparam int unsigned GW = PIX_W + 3;

  int gx_full;
  int gy_full;

  // Range is +/-4*(2^PIX_W-1), so truncating to PIX_W+3 signed bits is exact.
  always_comb begin
    gx_full = KW_SIDE * int'(c) + KW_MID * int'(f) + KW_SIDE * int'(i)
            - KW_SIDE * int'(a) - KW_MID * int'(d) - KW_SIDE * int'(g);
    gy_full = KW_SIDE * int'(g) + KW_MID * int'(h) + KW_SIDE * int'(i)
            - KW_SIDE * int'(a) - KW_MID * int'(b) - KW_SIDE * int'(c);
    gx = GW'(gx_full);
    gy = GW'(gy_full);
  end

endmodule

// File: rtl/sobel_window_engine.sv
// Three-stage valid/ready Sobel engine: gradients, |Gx|+|Gy|, saturate/threshold/count.
module sobel_window_engine
  import edge_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF,
  parameter int unsigned MAG_W = MAG_W_DEF,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      p0,  p1,  p2,  p3,  p4,  p5,
  input  logic [31:0]      p6,  p7,  p8,  p9,  p10, p11,
  input  logic [31:0]      p12, p13, p14, p15, p16, p17,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] threshold,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [MAG_W-1:0] mag0,
  output logic [MAG_W-1:0] mag1,
  output logic [MAG_W-1:0] mag2,
  output logic [MAG_W-1:0] mag3,
  output logic [3:0]       edges,
  output logic [CNT_W-1:0] edge_count,
  input  logic             count_clr
);

  localparam int unsigned GW      = PIX_W + 3;
  localparam int unsigned MAG_MAX = (1 << MAG_W) - 1;

  logic [31:0]      win [18];
  logic [PIX_W-1:0] px  [18];
  logic             unused_hi;

  assign win = '{p0, p1, p2, p3, p4, p5, p6, p7, p8,
                 p9, p10, p11, p12, p13, p14, p15, p16, p17};

  always_comb begin
    unused_hi = 1'b0;
    for (int n = 0; n < 18; n++) begin
      px[n]     = win[n][PIX_W-1:0];
      unused_hi = unused_hi ^ (^(win[n] >> PIX_W));
    end
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 inputs: centre k uses window columns k..k+2.
  logic signed [GW-1:0] gx_s0 [4];
  logic signed [GW-1:0] gy_s0 [4];

  for (genvar k = 0; k < 4; k++) begin : g_kern
    sobel_kernel3x3 #(
      .PIX_W(PIX_W)
    ) u_kern (
      .a (px[k]),
      .b (px[k+1]),
      .c (px[k+2]),
      .d (px[k+6]),
      .f (px[k+8]),
      .g (px[k+12]),
      .h (px[k+13]),
      .i (px[k+14]),
      .gx(gx_s0[k]),
      .gy(gy_s0[k])
    );
  end

  logic                 v1_q, v2_q, out_valid_q;
  logic signed [GW-1:0] gx_q  [4];
  logic signed [GW-1:0] gy_q  [4];
  logic [GW-1:0]        m_q   [4];
  logic [GW-1:0]        m_d   [4];
  logic [MAG_W-1:0]     mag_q [4];
  logic [MAG_W-1:0]     mag_d [4];
  logic [3:0]           edge_q, edge_d;
  logic [GW-1:0]        ax, ay;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           pop;
  logic [CNT_W:0]       cnt_sum;

  always_comb begin
    ax     = '0;
    ay     = '0;
    edge_d = '0;
    for (int k = 0; k < 4; k++) begin
      ax     = gx_q[k][GW-1] ? -gx_q[k] : gx_q[k];
      ay     = gy_q[k][GW-1] ? -gy_q[k] : gy_q[k];
      m_d[k] = ax + ay;
      if (32'(m_q[k]) > MAG_MAX) mag_d[k] = MAG_W'(MAG_MAX);
      else                       mag_d[k] = MAG_W'(m_q[k]);
      edge_d[k] = mag_d[k] > threshold;
    end
  end

  // Clear takes priority over the handshake it coincides with.
  always_comb begin
    pop = '0;
    for (int k = 0; k < 4; k++) pop = pop + 3'(edge_q[k]);
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(pop);
    cnt_d   = cnt_q;
    if (count_clr)                     cnt_d = '0;
    else if (out_valid_q && out_ready) cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      edge_q      <= '0;
      cnt_q       <= '0;
      for (int k = 0; k < 4; k++) begin
        gx_q[k]  <= '0;
        gy_q[k]  <= '0;
        m_q[k]   <= '0;
        mag_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (adv) begin
        v1_q        <= in_valid;
        v2_q        <= v1_q;
        out_valid_q <= v2_q;
        edge_q      <= edge_d;
        for (int k = 0; k < 4; k++) begin
          gx_q[k]  <= gx_s0[k];
          gy_q[k]  <= gy_s0[k];
          m_q[k]   <= m_d[k];
          mag_q[k] <= mag_d[k];
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign mag0       = mag_q[0];
  assign mag1       = mag_q[1];
  assign mag2       = mag_q[2];
  assign mag3       = mag_q[3];
  assign edges      = edge_q;
  assign edge_count = cnt_q;

endmodule

// File: doc/sobel_window_engine.md
Name: sobel_window_engine

Overview:
- Downstream consumer of shift_data_path. Takes its 18-word pixel window (3 rows x 6 columns) and computes Sobel gradient magnitudes for the 4 interior centre pixels each accepted cycle.
- Each magnitude is compared against a runtime threshold to produce per-pixel edge flags.
- Runs as a 3-stage valid/ready pipeline feeding the output/writeback stage.
- Keeps a saturating count of detected edges for frame statistics.

Parameters:
PIX_W, 8, pixel bit width; pixel taken from p*[PIX_W-1:0], upper bits ignored
MAG_W, 8, output magnitude width; magnitude saturates to 2^MAG_W-1
CNT_W, 16, edge counter width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
p0..p17  in  32 each  window words from shift_data_path; p0-p5 top row, p6-p11 middle, p12-p17 bottom, left to right
in_valid  in  1  window on p0..p17 is valid
in_ready  out  1  engine accepts window this cycle
threshold  in  MAG_W  edge threshold, sampled in stage 3
out_ready  in  1  downstream accepts output
out_valid  out  1  mag/edge outputs valid
mag0..mag3  out  MAG_W each  saturated |Gx|+|Gy| for centres p7,p8,p9,p10
edge  out  4  edge[k] = (magk > threshold)
edge_count  out  CNT_W  saturating count of edge bits delivered
count_clr  in  1  synchronous clear of edge_count

Behaviour:
- Reset: asynchronous and active-low. All valid flags, mag0..3, edge and edge_count go to 0 immediately on rst_n low. in_ready reads 1 once reset is released.
- Advance condition: adv = !out_valid || out_ready. All three stages load together when adv=1 and hold when adv=0. in_ready = adv (combinational). Bubbles are not collapsed.
- Transfers: input handshake = in_valid && in_ready. Output handshake = out_valid && out_ready.
- Latency: 3 cycles from input handshake to out_valid when there is no stall. Throughput is 1 window per cycle.
- Centre k (k=0..3): 3x3 neighbourhood spans columns k..k+2 of the window. Neighbours named a b c / d e f / g h i.
- S1: Gx = (c+2f+i)-(a+2d+g), Gy = (g+2h+i)-(a+2b+c). Both are signed, PIX_W+3 bits, and cannot overflow.
- S2: m = |Gx|+|Gy|, unsigned PIX_W+3 bits. Max is 8*(2^PIX_W-1), which fits.
- S3: magk = min(m, 2^MAG_W-1). edge[k] = magk > threshold (strict). threshold is sampled when S3 loads.
- Stall: while out_valid && !out_ready, mag0..3, edge and out_valid hold stable, and in_ready=0.
- edge_count: on each output handshake, add popcount(edge). Saturates at 2^CNT_W-1 and never wraps.
- count_clr: zeroes edge_count. If it coincides with a handshake, the clear wins and that handshake's edges are not counted.
- Reset mid-operation: all in-flight windows are discarded and nothing is emitted for them.

Decomposition:
- Shared package edge_pkg holds:
  - PIX_W / MAG_W defaults
  - the Sobel kernel weights as constants
  - grad_t, the signed PIX_W+3 type
- One natural sub-module, sobel_kernel3x3: combinational Gx/Gy for one 3x3 neighbourhood. It is instantiated 4 times in S1.
- The engine owns the pipeline registers, handshake, saturation, threshold and counter.

Test Plan:
- Flat field: all p = 100, threshold 0, one window -> after 3 cycles mag0..3=0, edge=0000, edge_count=0.
- Vertical step: columns 0-2 = 0, columns 3-5 = 200, threshold 128 -> mag = {0,255,255,0} (Gx=800 saturated), edge=0110, edge_count=2.
- Horizontal ramp: rows 10/20/30 gives Gy=80, mag=80 for all centres. With threshold 80 -> edge=0000; with threshold 79 -> edge=1111.
- Backpressure: stream 3 windows, hold out_ready=0 for 5 cycles after the first out_valid -> outputs stable, in_ready=0 throughout; all 3 results emerge in order with none lost or duplicated.
- Counter: preload via 16384 vertical-step windows (2 edges each). Expect edge_count=32768, then it saturates at 65535 after further windows. Asserting count_clr together with a handshake -> 0.
- Reset mid-stream: drop rst_n with 2 windows in flight -> out_valid=0 immediately and no stale output after release. The next window appears exactly 3 cycles after its accept.
